bft_stream_endpoint: RTL and testbench



---
 rtl/bft_pkt_pkg.sv | 49 ++++
 rtl/bft_sync_fifo.sv | 58 +++++
 rtl/bft_stream_endpoint.sv | 147 ++++++++++++++
 tb/tb_bft_stream_endpoint.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkt_pkg.sv
// BFT packet layout shared by the endpoint and its bench-facing helpers:
// field offsets, widths and pack/extract functions for 49-bit packets.
package bft_pkt_pkg;

    localparam int PACKET_BITS   = 49;
    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;

    localparam int VALID_BIT = 48;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_LSB  = 32;

    localparam logic [NUM_PORT_BITS-1:0] CREDIT_PORT = '0;

    typedef logic [PACKET_BITS-1:0]   bft_pkt_t;
    typedef logic [NUM_LEAF_BITS-1:0] bft_leaf_t;
    typedef logic [NUM_PORT_BITS-1:0] bft_port_t;
    typedef logic [NUM_ADDR_BITS-1:0] bft_addr_t;
    typedef logic [PAYLOAD_BITS-1:0]  bft_payload_t;

    function automatic bft_pkt_t pack_pkt(input bft_leaf_t leaf, input bft_port_t port,
                                          input bft_addr_t addr, input bft_payload_t payload);
        return {1'b1, leaf, port, addr, payload};
    endfunction

    function automatic logic pkt_valid(input bft_pkt_t pkt);
        return pkt[VALID_BIT];
    endfunction

    function automatic bft_leaf_t pkt_leaf(input bft_pkt_t pkt);
        return pkt[LEAF_LSB +: NUM_LEAF_BITS];
    endfunction

    function automatic bft_port_t pkt_port(input bft_pkt_t pkt);
        return pkt[PORT_LSB +: NUM_PORT_BITS];
    endfunction

    function automatic bft_addr_t pkt_addr(input bft_pkt_t pkt);
        return pkt[ADDR_LSB +: NUM_ADDR_BITS];
    endfunction

    function automatic bft_payload_t pkt_payload(input bft_pkt_t pkt);
        return pkt[PAYLOAD_BITS-1:0];
    endfunction

endpackage

// File: rtl/bft_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO is
// accepted only when a read retires the head in the same cycle.
module bft_sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   CNT_ONE = 1;
    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 do_wr;
    logic                 do_rd;

    assign empty   = (count == '0);
    assign full    = count[ADDR_BITS];
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    // validity and the read port is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bft_stream_endpoint.sv
// Network-side BFT endpoint: packetizes a valid/ack word stream under remote
// credit, depacketizes incoming data into an RX FIFO and returns credit.
module bft_stream_endpoint
    import bft_pkt_pkg::*;
#(
    parameter int FIFO_ADDR_BITS        = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int INIT_CREDIT           = 128
) (
    input  logic        clk_bft,
    input  logic        reset_bft,
    input  logic [48:0] din_leaf_bft2endpoint,
    output logic [48:0] dout_endpoint2bft,
    input  logic [4:0]  cfg_dest_leaf,
    input  logic [3:0]  cfg_dest_port,
    input  logic [31:0] s_din,
    input  logic        s_vld,
    output logic        s_ack,
    output logic [31:0] m_dout,
    output logic        m_vld,
    input  logic        m_ack,
    output logic [7:0]  credit_cnt,
    output logic        overflow
);

    localparam logic [1:0] TX_IDLE   = 2'd0;
    localparam logic [1:0] TX_CREDIT = 2'd1;
    localparam logic [1:0] TX_DATA   = 2'd2;

    localparam int DRAIN_BITS = $clog2(FREESPACE_UPDATE_SIZE + 1);
    localparam logic [DRAIN_BITS-1:0] DRAIN_LAST  = DRAIN_BITS'(FREESPACE_UPDATE_SIZE - 1);
    localparam logic [DRAIN_BITS-1:0] DRAIN_ONE   = 1;
    localparam logic [7:0]            CREDIT_MAX  = 8'(INIT_CREDIT);
    localparam logic [3:0]            PENDING_MAX = 4'd15;

    logic                  tx_en;
    logic [1:0]            tx_sel;
    logic [6:0]            seq;
    logic [3:0]            credit_pending;
    logic [3:0]            pending_next;
    logic [DRAIN_BITS-1:0] drain_cnt;
    logic                  drain_wrap;
    logic                  send_credit;
    logic                  send_data;

    logic                  rx_credit;
    logic                  rx_data;
    logic [31:0]           rx_payload;
    logic [7:0]            credit_inc;
    logic [8:0]            credit_sum;
    logic [7:0]            credit_next;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  unused_din_fields;

    // tx_en keeps s_ack low through reset even though credit_cnt resets full.
    assign s_ack = tx_en & (credit_pending == 4'd0) & (credit_cnt != 8'd0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it holding a value and no latch is inferred.
    always_comb begin
        tx_sel = TX_IDLE;
        if (credit_pending != 4'd0)
            tx_sel = TX_CREDIT;
        else if (s_vld && s_ack)
            tx_sel = TX_DATA;
    end

    assign send_credit = (tx_sel == TX_CREDIT);
    assign send_data   = (tx_sel == TX_DATA);

    assign rx_payload        = pkt_payload(din_leaf_bft2endpoint);
    assign rx_credit         = pkt_valid(din_leaf_bft2endpoint) &&
                               (pkt_port(din_leaf_bft2endpoint) == CREDIT_PORT);
    assign rx_data           = pkt_valid(din_leaf_bft2endpoint) && !rx_credit;
    assign credit_inc        = rx_credit ? rx_payload[7:0] : 8'd0;
    assign unused_din_fields = ^{pkt_leaf(din_leaf_bft2endpoint), pkt_addr(din_leaf_bft2endpoint)};

    // Sending needs credit_cnt != 0, so the decrement never underflows.
    always_comb begin
        credit_sum  = {1'b0, credit_cnt} + {1'b0, credit_inc} - {8'd0, send_data};
        credit_next = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credit_sum[7:0];
    end

    assign pop        = m_vld & m_ack;
    assign drain_wrap = pop && (drain_cnt == DRAIN_LAST);

    always_comb begin
        pending_next = credit_pending;
        if (drain_wrap && !send_credit && credit_pending != PENDING_MAX)
            pending_next = credit_pending + 4'd1;
        else if (!drain_wrap && send_credit)
            pending_next = credit_pending - 4'd1;
    end

    always_ff @(posedge clk_bft) begin
        if (reset_bft) begin
            tx_en             <= 1'b0;
            dout_endpoint2bft <= '0;
            seq               <= '0;
            credit_cnt        <= CREDIT_MAX;
            credit_pending    <= '0;
            drain_cnt         <= '0;
            overflow          <= 1'b0;
        end else begin
            tx_en          <= 1'b1;
            credit_cnt     <= credit_next;
            credit_pending <= pending_next;

            case (tx_sel)
                TX_CREDIT: dout_endpoint2bft <= pack_pkt(cfg_dest_leaf, CREDIT_PORT, 7'd0,
                                                         32'(FREESPACE_UPDATE_SIZE));
                TX_DATA:   dout_endpoint2bft <= pack_pkt(cfg_dest_leaf, cfg_dest_port, seq, s_din);
                default:   dout_endpoint2bft <= '0;
            endcase

            if (send_data) seq <= seq + 7'd1;

            if (drain_wrap)
                drain_cnt <= '0;
            else if (pop)
                drain_cnt <= drain_cnt + DRAIN_ONE;

            // A push at full is only lost when no pop frees a slot that cycle.
            if (rx_data && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    bft_sync_fifo #(
        .WIDTH     (32),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_rx_fifo (
        .clk     (clk_bft),
        .reset   (reset_bft),
        .wr_en   (rx_data),
        .wr_data (rx_payload),
        .rd_en   (m_ack),
        .rd_data (m_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_vld = ~fifo_empty;

endmodule

// File: tb/tb_bft_stream_endpoint.sv
// Directed bench for bft_stream_endpoint: credit flow, RX FIFO, credit
// return, overflow and reset behaviour against hand-computed values.
module tb_bft_stream_endpoint;

    localparam logic [4:0] DEST_LEAF = 5'd19;
    localparam logic [3:0] DEST_PORT = 4'd9;

    logic        clk_bft = 1'b0;
    logic        reset_bft;
    logic [48:0] din_leaf_bft2endpoint;
    logic [48:0] dout_endpoint2bft;
    logic [4:0]  cfg_dest_leaf;
    logic [3:0]  cfg_dest_port;
    logic [31:0] s_din;
    logic        s_vld;
    logic        s_ack;
    logic [31:0] m_dout;
    logic        m_vld;
    logic        m_ack;
    logic [7:0]  credit_cnt;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    bft_stream_endpoint dut (
        .clk_bft               (clk_bft),
        .reset_bft             (reset_bft),
        .din_leaf_bft2endpoint (din_leaf_bft2endpoint),
        .dout_endpoint2bft     (dout_endpoint2bft),
        .cfg_dest_leaf         (cfg_dest_leaf),
        .cfg_dest_port         (cfg_dest_port),
        .s_din                 (s_din),
        .s_vld                 (s_vld),
        .s_ack                 (s_ack),
        .m_dout                (m_dout),
        .m_vld                 (m_vld),
        .m_ack                 (m_ack),
        .credit_cnt            (credit_cnt),
        .overflow              (overflow)
    );

    always #5 clk_bft = ~clk_bft;

    function automatic logic [48:0] mk_pkt(input logic [4:0] leaf, input logic [3:0] port,
                                           input logic [6:0] addr, input logic [31:0] payload);
        return {1'b1, leaf, port, addr, payload};
    endfunction

    function automatic logic [48:0] exp_data(input logic [6:0] sq, input logic [31:0] payload);
        return {1'b1, DEST_LEAF, DEST_PORT, sq, payload};
    endfunction

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    task automatic do_reset();
        reset_bft = 1'b1;
        din_leaf_bft2endpoint = '0;
        s_vld = 1'b0;
        s_din = '0;
        m_ack = 1'b0;
        tick();
        tick();
        reset_bft = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_bft = 1'b1;
        din_leaf_bft2endpoint = '0;
        s_vld = 1'b0;
        s_din = '0;
        m_ack = 1'b0;
        tick();
        tick();
        n_cmp++; if (dout_endpoint2bft !== 49'd0) begin n_err++; $display("FAIL reset_dout: got %h want %h", dout_endpoint2bft, 49'd0); end
        n_cmp++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL reset_s_ack: got %b want 0", s_ack); end
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL reset_m_vld: got %b want 0", m_vld); end
        n_cmp++; if (m_dout !== 32'd0) begin n_err++; $display("FAIL reset_m_dout: got %h want 0", m_dout); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (credit_cnt !== 8'd128) begin n_err++; $display("FAIL reset_credit: got %0d want 128", credit_cnt); end
        reset_bft = 1'b0;
        tick();
        n_cmp++; if (s_ack !== 1'b1) begin n_err++; $display("FAIL reset_release_s_ack: got %b want 1", s_ack); end
        n_cmp++; if (dout_endpoint2bft !== 49'd0) begin n_err++; $display("FAIL reset_release_dout: got %h want 0", dout_endpoint2bft); end
    endtask

    task automatic test_credit_exhaustion();
        int k;
        k = 0;
        do_reset();
        s_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            s_din = 32'(i);
            tick();
            if (dout_endpoint2bft[48]) begin
                n_cmp++;
                if (dout_endpoint2bft !== exp_data(7'(k), 32'(k))) begin
                    n_err++;
                    $display("FAIL exhaust_pkt%0d: got %h want %h", k, dout_endpoint2bft, exp_data(7'(k), 32'(k)));
                end
                k++;
            end
        end
        n_cmp++; if (k != 128) begin n_err++; $display("FAIL exhaust_count: got %0d want 128", k); end
        n_cmp++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL exhaust_s_ack: got %b want 0", s_ack); end
        n_cmp++; if (credit_cnt !== 8'd0) begin n_err++; $display("FAIL exhaust_credit: got %0d want 0", credit_cnt); end
    endtask

    // Continues from the exhausted state left by test_credit_exhaustion.
    task automatic test_credit_replenish();
        int k;
        k = 0;
        s_din = 32'hDEAD_BEEF;
        din_leaf_bft2endpoint = mk_pkt(5'd0, 4'd0, 7'd0, 32'd64);
        tick();
        din_leaf_bft2endpoint = '0;
        n_cmp++; if (credit_cnt !== 8'd64) begin n_err++; $display("FAIL replenish_credit: got %0d want 64", credit_cnt); end
        n_cmp++; if (s_ack !== 1'b1) begin n_err++; $display("FAIL replenish_s_ack: got %b want 1", s_ack); end
        for (int j = 0; j < 100; j++) begin
            s_din = 32'(1000 + j);
            tick();
            if (dout_endpoint2bft[48]) begin
                n_cmp++;
                if (dout_endpoint2bft !== exp_data(7'(k), 32'(1000 + k))) begin
                    n_err++;
                    $display("FAIL replenish_pkt%0d: got %h want %h", k, dout_endpoint2bft, exp_data(7'(k), 32'(1000 + k)));
                end
                k++;
            end
        end
        n_cmp++; if (k != 64) begin n_err++; $display("FAIL replenish_count: got %0d want 64", k); end
        n_cmp++; if (credit_cnt !== 8'd0) begin n_err++; $display("FAIL replenish_end_credit: got %0d want 0", credit_cnt); end
        s_vld = 1'b0;
        tick();
    endtask

    task automatic test_credit_saturation();
        do_reset();
        din_leaf_bft2endpoint = mk_pkt(5'd0, 4'd0, 7'd0, 32'd64);
        tick();
        din_leaf_bft2endpoint = '0;
        n_cmp++; if (credit_cnt !== 8'd128) begin n_err++; $display("FAIL sat_credit: got %0d want 128", credit_cnt); end
        s_vld = 1'b1;
        s_din = 32'h1234;
        tick();
        tick();
        tick();
        n_cmp++; if (credit_cnt !== 8'd125) begin n_err++; $display("FAIL sat_after_send: got %0d want 125", credit_cnt); end
        // Only payload[7:0] counts: 125 - 1 + 3.
        din_leaf_bft2endpoint = mk_pkt(5'd4, 4'd0, 7'd0, 32'h0000_0103);
        tick();
        n_cmp++; if (credit_cnt !== 8'd127) begin n_err++; $display("FAIL sat_send_and_credit: got %0d want 127", credit_cnt); end
        din_leaf_bft2endpoint = mk_pkt(5'd0, 4'd0, 7'd0, 32'd64);
        tick();
        n_cmp++; if (credit_cnt !== 8'd128) begin n_err++; $display("FAIL sat_clamp_with_send: got %0d want 128", credit_cnt); end
        din_leaf_bft2endpoint = '0;
        s_vld = 1'b0;
        tick();
    endtask

    task automatic test_rx_credit_return();
        int  acc;
        int  ndata;
        int  ncred;
        logic will_acc;
        logic prev_cred;
        acc = 0;
        ndata = 0;
        ncred = 0;
        prev_cred = 1'b0;
        do_reset();
        m_ack = 1'b1;
        s_vld = 1'b1;
        for (int c = 0; c < 72; c++) begin
            s_din = 32'h5000 + 32'(acc);
            will_acc = s_ack;
            if (c < 64)
                din_leaf_bft2endpoint = mk_pkt(5'd2, 4'd3, 7'(c), 32'hA000 + 32'(c));
            else
                din_leaf_bft2endpoint = '0;
            tick();
            if (will_acc) acc++;
            if (c < 64) begin
                n_cmp++;
                if ({m_vld, m_dout} !== {1'b1, 32'hA000 + 32'(c)}) begin
                    n_err++;
                    $display("FAIL rx_word%0d: got vld=%b %h want vld=1 %h", c, m_vld, m_dout, 32'hA000 + 32'(c));
                end
            end
            if (prev_cred) begin
                n_cmp++;
                if (dout_endpoint2bft !== exp_data(7'(ndata), 32'h5000 + 32'(ndata))) begin
                    n_err++;
                    $display("FAIL rx_stalled_word: got %h want %h", dout_endpoint2bft, exp_data(7'(ndata), 32'h5000 + 32'(ndata)));
                end
            end
            prev_cred = 1'b0;
            if (dout_endpoint2bft[48]) begin
                if (dout_endpoint2bft[42:39] == 4'd0) begin
                    ncred++;
                    prev_cred = 1'b1;
                    n_cmp++;
                    if (dout_endpoint2bft !== {1'b1, DEST_LEAF, 4'd0, 7'd0, 32'd64}) begin
                        n_err++;
                        $display("FAIL rx_credit_pkt: got %h want %h", dout_endpoint2bft, {1'b1, DEST_LEAF, 4'd0, 7'd0, 32'd64});
                    end
                end else begin
                    n_cmp++;
                    if (dout_endpoint2bft !== exp_data(7'(ndata), 32'h5000 + 32'(ndata))) begin
                        n_err++;
                        $display("FAIL rx_tx_pkt%0d: got %h want %h", ndata, dout_endpoint2bft, exp_data(7'(ndata), 32'h5000 + 32'(ndata)));
                    end
                    ndata++;
                end
            end
        end
        n_cmp++; if (ncred != 1) begin n_err++; $display("FAIL rx_credit_count: got %0d want 1", ncred); end
        n_cmp++; if (ndata != acc) begin n_err++; $display("FAIL rx_tx_count: got %0d want %0d", ndata, acc); end
        n_cmp++; if (acc != 71) begin n_err++; $display("FAIL rx_tx_accepted: got %0d want 71", acc); end
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL rx_drained: got %b want 0", m_vld); end
        s_vld = 1'b0;
        m_ack = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        do_reset();
        for (int j = 0; j < 128; j++) begin
            din_leaf_bft2endpoint = mk_pkt(5'd1, 4'd5, 7'd0, 32'hB000 + 32'(j));
            tick();
        end
        din_leaf_bft2endpoint = '0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
        // Push and pop together while full: no overflow, occupancy stays 128.
        din_leaf_bft2endpoint = mk_pkt(5'd1, 4'd5, 7'd0, 32'h0000_CCCC);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_push_pop_full: got %b want 0", overflow); end
        n_cmp++; if (m_dout !== 32'hB001) begin n_err++; $display("FAIL ovf_head_after_pop: got %h want %h", m_dout, 32'hB001); end
        din_leaf_bft2endpoint = mk_pkt(5'd1, 4'd5, 7'd0, 32'h0000_DEAD);
        tick();
        din_leaf_bft2endpoint = '0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
        m_ack = 1'b1;
        for (int k = 0; k < 128; k++) begin
            exp_w = (k < 127) ? 32'hB001 + 32'(k) : 32'h0000_CCCC;
            n_cmp++;
            if ({m_vld, m_dout} !== {1'b1, exp_w}) begin
                n_err++;
                $display("FAIL ovf_drain%0d: got vld=%b %h want vld=1 %h", k, m_vld, m_dout, exp_w);
            end
            tick();
        end
        m_ack = 1'b0;
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL ovf_drop_129th: got vld=%b %h want vld=0", m_vld, m_dout); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    // Runs without a preceding reset so overflow and FIFO state are live.
    task automatic test_reset_mid_burst();
        s_vld = 1'b1;
        m_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            s_din = 32'(c);
            din_leaf_bft2endpoint = mk_pkt(5'd2, 4'd3, 7'd0, 32'hE000 + 32'(c));
            tick();
        end
        n_cmp++; if (m_vld !== 1'b1) begin n_err++; $display("FAIL mid_burst_fill: got %b want 1", m_vld); end
        reset_bft = 1'b1;
        tick();
        n_cmp++; if (dout_endpoint2bft !== 49'd0) begin n_err++; $display("FAIL mid_reset_dout: got %h want 0", dout_endpoint2bft); end
        n_cmp++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL mid_reset_s_ack: got %b want 0", s_ack); end
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL mid_reset_m_vld: got %b want 0", m_vld); end
        n_cmp++; if (m_dout !== 32'd0) begin n_err++; $display("FAIL mid_reset_m_dout: got %h want 0", m_dout); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (credit_cnt !== 8'd128) begin n_err++; $display("FAIL mid_reset_credit: got %0d want 128", credit_cnt); end
        reset_bft = 1'b0;
        din_leaf_bft2endpoint = '0;
        s_vld = 1'b0;
        tick();
        n_cmp++; if (s_ack !== 1'b1) begin n_err++; $display("FAIL mid_release_s_ack: got %b want 1", s_ack); end
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL mid_release_m_vld: got %b want 0", m_vld); end
        s_vld = 1'b1;
        s_din = 32'd77;
        tick();
        s_vld = 1'b0;
        n_cmp++;
        if (dout_endpoint2bft !== exp_data(7'd0, 32'd77)) begin
            n_err++;
            $display("FAIL mid_first_pkt: got %h want %h", dout_endpoint2bft, exp_data(7'd0, 32'd77));
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_dest_leaf = DEST_LEAF;
        cfg_dest_port = DEST_PORT;
        reset_bft = 1'b1;
        din_leaf_bft2endpoint = '0;
        s_din = '0;
        s_vld = 1'b0;
        m_ack = 1'b0;
        #1;
        test_reset();
        test_credit_exhaustion();
        test_credit_replenish();
        test_credit_saturation();
        test_rx_credit_return();
        test_overflow();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
